keypad_entry: RTL and testbench

//   Upstream stage of the door controller. Turns single keypad strobes (digits 0-9, CLEAR, ENTER)

---
 rtl/keypad_entry_if.sv | 30 +++
 rtl/keypad_entry.sv | 121 ++++++++++++
 tb/tb_keypad_entry.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_if
// Description : Key strobe input and password/status output bundle of the
//               keypad entry stage. The master side supplies keys and
//               observes results; the slave side is the entry stage itself.
// Revision    : 1.0  initial release
// ============================================================================
interface keypad_entry_if #(
  parameter int PW_WIDTH = 14
);
  logic                key_valid;
  logic [3:0]          key_code;
  logic [PW_WIDTH-1:0] password_out;
  logic                password_valid;
  logic [2:0]          digit_count;
  logic                busy;
  logic                entry_error;

  modport master (
    output key_valid, key_code,
    input  password_out, password_valid, digit_count, busy, entry_error
  );

  modport slave (
    input  key_valid, key_code,
    output password_out, password_valid, digit_count, busy, entry_error
  );
endinterface
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry
// Description : Collects single keypad strobes into a DIGITS-long decimal
//               code, converts it to binary on the fly and publishes it as a
//               password with a one-cycle valid pulse. Partial entries are
//               discarded after TIMEOUT_CYCLES idle cycles.
// Revision    : 1.0  initial release
// ============================================================================
module keypad_entry #(
  parameter int DIGITS         = 4,
  parameter int PW_WIDTH       = 14,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  wire logic     clk,
  input  wire logic     reset,
  keypad_entry_if.slave kp
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]         MAX_COUNT  = 3'(DIGITS);
  localparam logic [3:0]         KEY_CLEAR  = 4'd10;
  localparam logic [3:0]         KEY_ENTER  = 4'd11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ENTRY = 1'b1
  } state_t;

  state_t              state;
  logic [PW_WIDTH-1:0] acc;
  logic [TIMER_W-1:0]  timer;

  logic                is_digit;
  logic                is_clear;
  logic                is_enter;
  logic [PW_WIDTH-1:0] digit_ext;
  logic [PW_WIDTH-1:0] acc_shifted;

  // Key decode and decimal accumulate (acc*10 + d); reserved codes decode to nothing
  always_comb begin
    is_digit    = kp.key_valid && (kp.key_code <= 4'd9);
    is_clear    = kp.key_valid && (kp.key_code == KEY_CLEAR);
    is_enter    = kp.key_valid && (kp.key_code == KEY_ENTER);
    digit_ext   = PW_WIDTH'(kp.key_code);
    acc_shifted = (acc * PW_WIDTH'(10)) + digit_ext;
  end

  // Entry FSM; every output is a register updated alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      acc               <= '0;
      timer             <= '0;
      kp.digit_count    <= 3'd0;
      kp.password_out   <= '0;
      kp.password_valid <= 1'b0;
      kp.entry_error    <= 1'b0;
      kp.busy           <= 1'b0;
    end else begin
      kp.password_valid <= 1'b0;
      kp.entry_error    <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (is_digit) begin
            acc            <= digit_ext;
            kp.digit_count <= 3'd1;
            state          <= ENTRY;
            kp.busy        <= 1'b1;
          end
        end

        ENTRY: begin
          if (is_digit) begin
            // A digit always counts as activity, even when it is dropped
            timer <= '0;
            if (kp.digit_count < MAX_COUNT) begin
              acc            <= acc_shifted;
              kp.digit_count <= kp.digit_count + 3'd1;
            end else begin
              kp.entry_error <= 1'b1;
            end
          end else if (is_enter || is_clear) begin
            if (is_enter) begin
              if (kp.digit_count == MAX_COUNT) begin
                kp.password_out   <= acc;
                kp.password_valid <= 1'b1;
              end else begin
                kp.entry_error <= 1'b1;
              end
            end
            acc            <= '0;
            kp.digit_count <= 3'd0;
            timer          <= '0;
            state          <= IDLE;
            kp.busy        <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            // Inactivity: discard the partial code
            kp.entry_error <= 1'b1;
            acc            <= '0;
            kp.digit_count <= 3'd0;
            timer          <= '0;
            state          <= IDLE;
            kp.busy        <= 1'b0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          kp.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_entry
// Description : Directed self-checking bench for keypad_entry. Keys are
//               applied on the falling edge, results observed 1 time unit
//               after the rising edge that consumed them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_entry;

  localparam int DIGITS   = 4;
  localparam int PW_WIDTH = 14;
  localparam int TO       = 20;
  localparam logic [3:0] K_CLR = 4'd10;
  localparam logic [3:0] K_ENT = 4'd11;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  keypad_entry_if #(.PW_WIDTH(PW_WIDTH)) kp ();

  keypad_entry #(
    .DIGITS         (DIGITS),
    .PW_WIDTH       (PW_WIDTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  // One key for exactly one cycle; returns just after the consuming edge
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    kp.key_valid = 1'b1;
    kp.key_code  = code;
    @(posedge clk);
    #1;
    kp.key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    n_vec++; if (kp.password_out !== 14'd0) begin n_fail++; $display("FAIL reset_pw got %0d want 0", kp.password_out); end
    n_vec++; if (kp.password_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pv got %b want 0", kp.password_valid); end
    n_vec++; if (kp.entry_error !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", kp.entry_error); end
    n_vec++; if (kp.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", kp.busy); end
    n_vec++; if (kp.digit_count !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", kp.digit_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    for (int i = 1; i <= 4; i++) begin
      press(4'd1);
      n_vec++; if (kp.digit_count !== 3'(i)) begin n_fail++; $display("FAIL basic_cnt got %0d want %0d", kp.digit_count, i); end
      n_vec++; if (kp.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", kp.busy); end
    end
    press(K_ENT);
    n_vec++; if (kp.password_valid !== 1'b1) begin n_fail++; $display("FAIL basic_pv got %b want 1", kp.password_valid); end
    n_vec++; if (kp.password_out !== 14'd1111) begin n_fail++; $display("FAIL basic_pw got %0d want 1111", kp.password_out); end
    n_vec++; if (kp.digit_count !== 3'd0) begin n_fail++; $display("FAIL basic_cnt0 got %0d want 0", kp.digit_count); end
    n_vec++; if (kp.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %b want 0", kp.busy); end
    n_vec++; if (kp.entry_error !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", kp.entry_error); end
    idle(1);
    n_vec++; if (kp.password_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pv_drop got %b want 0", kp.password_valid); end
    n_vec++; if (kp.password_out !== 14'd1111) begin n_fail++; $display("FAIL basic_pw_hold got %0d want 1111", kp.password_out); end
  endtask

  task automatic test_clear;
    press(4'd2);
    press(4'd2);
    press(K_CLR);
    n_vec++; if (kp.entry_error !== 1'b0) begin n_fail++; $display("FAIL clear_err got %b want 0", kp.entry_error); end
    n_vec++; if (kp.busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy got %b want 0", kp.busy); end
    n_vec++; if (kp.digit_count !== 3'd0) begin n_fail++; $display("FAIL clear_cnt got %0d want 0", kp.digit_count); end
    for (int i = 0; i < 4; i++) press(4'd3);
    press(K_ENT);
    n_vec++; if (kp.password_valid !== 1'b1) begin n_fail++; $display("FAIL clear_pv got %b want 1", kp.password_valid); end
    n_vec++; if (kp.password_out !== 14'd3333) begin n_fail++; $display("FAIL clear_pw got %0d want 3333", kp.password_out); end
  endtask

  task automatic test_short_enter;
    idle(1);
    press(4'd5);
    press(K_ENT);
    n_vec++; if (kp.entry_error !== 1'b1) begin n_fail++; $display("FAIL short_err got %b want 1", kp.entry_error); end
    n_vec++; if (kp.password_valid !== 1'b0) begin n_fail++; $display("FAIL short_pv got %b want 0", kp.password_valid); end
    n_vec++; if (kp.password_out !== 14'd3333) begin n_fail++; $display("FAIL short_pw got %0d want 3333", kp.password_out); end
    n_vec++; if (kp.busy !== 1'b0) begin n_fail++; $display("FAIL short_busy got %b want 0", kp.busy); end
    idle(1);
    n_vec++; if (kp.entry_error !== 1'b0) begin n_fail++; $display("FAIL short_err_drop got %b want 0", kp.entry_error); end
  endtask

  task automatic test_overflow;
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    press(4'd5);
    n_vec++; if (kp.entry_error !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b want 1", kp.entry_error); end
    n_vec++; if (kp.digit_count !== 3'd4) begin n_fail++; $display("FAIL ovf_cnt got %0d want 4", kp.digit_count); end
    n_vec++; if (kp.busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy got %b want 1", kp.busy); end
    press(K_ENT);
    n_vec++; if (kp.password_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_pv got %b want 1", kp.password_valid); end
    n_vec++; if (kp.password_out !== 14'd1234) begin n_fail++; $display("FAIL ovf_pw got %0d want 1234", kp.password_out); end
    n_vec++; if (kp.entry_error !== 1'b0) begin n_fail++; $display("FAIL ovf_err_enter got %b want 0", kp.entry_error); end
  endtask

  task automatic test_idle_keys;
    press(K_ENT);
    n_vec++; if (kp.entry_error !== 1'b0 || kp.busy !== 1'b0) begin n_fail++; $display("FAIL idle_enter err=%b busy=%b want 0 0", kp.entry_error, kp.busy); end
    press(K_CLR);
    n_vec++; if (kp.entry_error !== 1'b0 || kp.busy !== 1'b0) begin n_fail++; $display("FAIL idle_clear err=%b busy=%b want 0 0", kp.entry_error, kp.busy); end
    press(4'd14);
    n_vec++; if (kp.busy !== 1'b0 || kp.password_out !== 14'd1234) begin n_fail++; $display("FAIL idle_rsvd busy=%b pw=%0d want 0 1234", kp.busy, kp.password_out); end
  endtask

  task automatic test_timeout;
    logic early;
    press(4'd9);
    press(4'd9);
    early = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      idle(1);
      if (kp.entry_error !== 1'b0 || kp.busy !== 1'b1) early = 1'b1;
    end
    n_vec++; if (early !== 1'b0) begin n_fail++; $display("FAIL to_early got %b want 0", early); end
    idle(1);
    n_vec++; if (kp.entry_error !== 1'b1) begin n_fail++; $display("FAIL to_err got %b want 1", kp.entry_error); end
    n_vec++; if (kp.busy !== 1'b0) begin n_fail++; $display("FAIL to_busy got %b want 0", kp.busy); end
    n_vec++; if (kp.digit_count !== 3'd0) begin n_fail++; $display("FAIL to_cnt got %0d want 0", kp.digit_count); end
    idle(1);
    n_vec++; if (kp.entry_error !== 1'b0) begin n_fail++; $display("FAIL to_err_drop got %b want 0", kp.entry_error); end
    for (int i = 0; i < 4; i++) press(4'd9);
    press(K_ENT);
    n_vec++; if (kp.password_out !== 14'd9999 || kp.password_valid !== 1'b1) begin n_fail++; $display("FAIL to_pw pw=%0d pv=%b want 9999 1", kp.password_out, kp.password_valid); end
  endtask

  task automatic test_key_wins;
    press(4'd8);
    idle(TO - 1);
    n_vec++; if (kp.busy !== 1'b1) begin n_fail++; $display("FAIL win_pre_busy got %b want 1", kp.busy); end
    press(4'd8);
    n_vec++; if (kp.entry_error !== 1'b0) begin n_fail++; $display("FAIL win_err got %b want 0", kp.entry_error); end
    n_vec++; if (kp.digit_count !== 3'd2) begin n_fail++; $display("FAIL win_cnt got %0d want 2", kp.digit_count); end
    idle(TO - 1);
    n_vec++; if (kp.busy !== 1'b1 || kp.entry_error !== 1'b0) begin n_fail++; $display("FAIL win_restart busy=%b err=%b want 1 0", kp.busy, kp.entry_error); end
    idle(1);
    n_vec++; if (kp.entry_error !== 1'b1 || kp.busy !== 1'b0) begin n_fail++; $display("FAIL win_to err=%b busy=%b want 1 0", kp.entry_error, kp.busy); end
  endtask

  task automatic test_reserved_timer;
    press(4'd5);
    idle(TO - 2);
    press(4'd12);
    n_vec++; if (kp.entry_error !== 1'b0 || kp.digit_count !== 3'd1) begin n_fail++; $display("FAIL rsvd_keep err=%b cnt=%0d want 0 1", kp.entry_error, kp.digit_count); end
    idle(1);
    n_vec++; if (kp.entry_error !== 1'b1 || kp.busy !== 1'b0) begin n_fail++; $display("FAIL rsvd_to err=%b busy=%b want 1 0", kp.entry_error, kp.busy); end
  endtask

  task automatic test_reset_mid_entry;
    press(4'd7);
    press(4'd7);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_vec++; if (kp.digit_count !== 3'd0 || kp.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid cnt=%0d busy=%b want 0 0", kp.digit_count, kp.busy); end
    n_vec++; if (kp.password_out !== 14'd0) begin n_fail++; $display("FAIL rst_mid_pw got %0d want 0", kp.password_out); end
    @(negedge clk);
    reset = 1'b0;
    press(4'd0);
    press(4'd13);
    press(4'd0);
    press(4'd0);
    press(4'd15);
    n_vec++; if (kp.digit_count !== 3'd3) begin n_fail++; $display("FAIL rst_rsvd_cnt got %0d want 3", kp.digit_count); end
    press(4'd1);
    press(K_ENT);
    n_vec++; if (kp.password_out !== 14'd1 || kp.password_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pw pw=%0d pv=%b want 1 1", kp.password_out, kp.password_valid); end
  endtask

  task automatic test_back_to_back;
    press(4'd4);
    press(4'd3);
    press(4'd2);
    press(4'd1);
    press(K_ENT);
    n_vec++; if (kp.password_out !== 14'd4321 || kp.password_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_pw pw=%0d pv=%b want 4321 1", kp.password_out, kp.password_valid); end
    press(4'd6);
    n_vec++; if (kp.password_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_pv_drop got %b want 0", kp.password_valid); end
    n_vec++; if (kp.busy !== 1'b1 || kp.digit_count !== 3'd1) begin n_fail++; $display("FAIL b2b_next busy=%b cnt=%0d want 1 1", kp.busy, kp.digit_count); end
    press(K_CLR);
  endtask

  initial begin
    kp.key_valid = 1'b0;
    kp.key_code  = 4'd0;
    test_reset();
    test_basic();
    test_clear();
    test_short_enter();
    test_overflow();
    test_idle_keys();
    test_timeout();
    test_key_wins();
    test_reserved_timer();
    test_reset_mid_entry();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
